// File: rtl/seq_restoring_divider_if.sv
// seq_restoring_divider_if: start/done handshake and operand/result bundle for the sequential divider
interface seq_restoring_divider_if #(parameter int WIDTH = 4);
  logic start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic busy;
  logic done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic div_by_zero;
  modport master (output start, dividend, divisor, input busy, done, quotient, remainder, div_by_zero);
  modport slave (input start, dividend, divisor, output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: restoring shift-subtract divider, one step per clock (SIGNED_DIV_EN selects two's complement operands)
module seq_restoring_divider #(parameter int WIDTH = 4) (
  input logic clk,
  input logic rst,
  seq_restoring_divider_if.slave s
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH:0] r, r_sh, r_nx;
  logic [WIDTH+1:0] sum;
  logic [WIDTH-1:0] q, q_nx, d, a_in, b_in, q_fin, r_fin;
  logic [CW-1:0] cnt;
  logic last, zero;
  assign zero = s.divisor == '0;
  assign last = cnt == CW'(WIDTH - 1);
  assign r_sh = (WIDTH+1)'({r, q[WIDTH-1]});
  assign sum = {1'b0, r_sh} + {2'b01, ~d} + (WIDTH+2)'(1);
  assign r_nx = sum[WIDTH+1] ? sum[WIDTH:0] : r_sh;
  assign q_nx = {q[WIDTH-2:0], sum[WIDTH+1]};
`ifdef SIGNED_DIV_EN
  logic sa, sb;
  assign a_in = s.dividend[WIDTH-1] ? -s.dividend : s.dividend;
  assign b_in = s.divisor[WIDTH-1] ? -s.divisor : s.divisor;
  assign q_fin = (sa ^ sb) ? -q_nx : q_nx;
  assign r_fin = sa ? -r_nx[WIDTH-1:0] : r_nx[WIDTH-1:0];
  // remember operand signs so the magnitude result can be corrected at completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa <= 1'b0;
      sb <= 1'b0;
    end else if (state == IDLE && s.start) begin
      sa <= s.dividend[WIDTH-1];
      sb <= s.divisor[WIDTH-1];
    end
  end
`else
  assign a_in = s.dividend;
  assign b_in = s.divisor;
  assign q_fin = q_nx;
  assign r_fin = r_nx[WIDTH-1:0];
`endif
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // next state and status outputs; a zero divisor skips straight to DONE
  always_comb begin
    state_nx = state;
    s.busy = state != IDLE;
    s.done = state == DONE;
    state_nx = state == IDLE ? (s.start ? (zero ? DONE : CALC) : IDLE) :
               state == CALC ? (last ? DONE : CALC) : IDLE;
  end
  // datapath: capture on accept, iterate in CALC, publish results only on completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r <= '0;
      q <= '0;
      d <= '0;
      cnt <= '0;
      s.quotient <= '0;
      s.remainder <= '0;
      s.div_by_zero <= 1'b0;
    end else if (state == IDLE && s.start) begin
      r <= '0;
      q <= a_in;
      d <= b_in;
      cnt <= '0;
      if (zero) begin
        s.quotient <= '1;
        s.remainder <= s.dividend;
        s.div_by_zero <= 1'b1;
      end
    end else if (state == CALC) begin
      r <= r_nx;
      q <= q_nx;
      cnt <= cnt + CW'(1);
      if (last) begin
        s.quotient <= q_fin;
        s.remainder <= r_fin;
        s.div_by_zero <= 1'b0;
      end
    end
  end
endmodule
